pre_comm_remap: RTL and testbench
=================================

Name: pre_comm_remap

Overview:
Parametrised address remapper placed between the input channels and the pre-commutator. It spreads nOUT commutator outputs evenly over nPIPE parallel pipelines instead of the power-of-two split. Each input channel has an independent 2-stage pipeline with req/rdy backpressure. Out-of-range addresses are dropped and counted, and a balanced/identity mode is selectable at runtime.

Parameters:
nIN, 8, number of input channels
nOUT, 52, number of commutator output channels
nPIPE, 4, number of parallel commutator pipelines (2 <= nPIPE <= nOUT)
wD, 25, data width
wCNT, 16, per-channel drop counter width
Derived constants:
- wA_OUT = $clog2(nOUT)
- nCH = ceil(nOUT/nPIPE)
- wA_CH = $clog2(nCH)
- wP = $clog2(nPIPE)
- wA_MAP = wP + wA_CH

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
mode_bal  in  1  1 = balanced remap, 0 = identity (zero-extended address)
req_in  in  nIN  per-channel request from upstream
data_in  in  wD*nIN  packed data, channel i at [(i+1)*wD-1:i*wD]
addr_in  in  wA_OUT*nIN  packed commutator output address
rdy_out  out  nIN  per-channel ready to upstream
req_out  out  nIN  per-channel request to pre-commutator
data_out  out  wD*nIN  packed data
addr_out  out  wA_MAP*nIN  packed remapped address {pipe, local}
rdy_in  in  nIN  per-channel ready from pre-commutator
err_out  out  nIN  one-cycle pulse per dropped beat
drop_cnt  out  wCNT*nIN  saturating count of dropped beats per channel

Behaviour:
- Reset is asynchronous and active-low.
  - While reset = 0: all valid bits, req_out, err_out, data_out, addr_out and drop_cnt = 0; rdy_out = 0.
  - After release, rdy_out = 1 on the first cycle.
- Channels are fully independent; no cross-channel arbitration.
- Handshakes:
  - Beat accepted at an edge where req_in[i] & rdy_out[i].
  - Beat delivered at an edge where req_out[i] & rdy_in[i].
- Stage S1 (valid v1): captures data, addr and mode_bal, and computes:
  - p = count of k in 1..nPIPE-1 with addr >= k*nCH (comparator ladder; no divider);
  - oob = (addr >= nOUT).
- Stage S2 (valid v2): registered outputs.
  - local = addr - p*nCH, wA_CH bits.
  - addr_out = mode ? {p[wP-1:0], local} : addr zero-extended to wA_MAP.
  - req_out = v2.
- Advance rules:
  - S2 loads when !v2 | rdy_in.
  - S1 moves to S2 when v1 & (!v2 | rdy_in).
  - rdy_out = !v1 | !v2 | rdy_in. This combinational rdy_in->rdy_out path is intentional.
- Latency: a beat accepted at edge t appears on req_out after edge t+1 with no backpressure. Throughput is 1 beat/cycle/channel.
- Stall: while req_out & !rdy_in, data_out and addr_out hold stable. Full when v1 & v2 & !rdy_in, so rdy_out = 0.
- Out-of-range beats (oob = 1):
  - Discarded on S1 exit and never enter S2. The move does not require S2 space, so an oob beat leaves S1 even when S2 is stalled.
  - err_out pulses high the following cycle.
  - drop_cnt increments by 1 and saturates at 2**wCNT-1 (no wrap).
- mode_bal is sampled per beat at S1 capture. Changing it mid-flight does not alter beats already in S1/S2.
- Reset asserted mid-operation: in-flight beats are lost immediately and counters clear. No partial outputs after release.
- Uneven split: the last pipeline handles nOUT-(nPIPE-1)*nCH channels. Local codes >= nCH never occur for in-range input.
- Reference case nPIPE=2: output equals addr + (2**wA_CH - nCH) when addr >= nCH, otherwise addr.

Test Plan:
1. nOUT=52, nPIPE=4, mode_bal=1, rdy_in=1; send addr 0, 12, 13, 27, 51 -> addr_out 0, 12, 16, 33, 60, each 2 cycles after acceptance, data unchanged.
2. nOUT=40, nPIPE=2; addr 19, 20, 25 -> addr_out 19, 32, 37. With mode_bal=0: addr 25 -> 25.
3. Backpressure: stream 4 beats, hold rdy_in=0 for 5 cycles -> rdy_out drops after 2 accepted, req_out/data_out stable. Release -> remaining beats delivered in order, none lost or duplicated.
4. Out of range: nOUT=52, addr 55 with S2 stalled -> beat dropped, err_out one-cycle pulse, drop_cnt 0->1, next valid beat unaffected. Force wCNT=2 and drop 5 beats -> drop_cnt saturates at 3.
5. Reset: drive reset=0 asynchronously mid-stream with v1=v2=1 -> req_out, err_out, drop_cnt = 0 without a clock edge. After release, rdy_out=1 and the first new beat latency is 2.
6. Toggle mode_bal every cycle on a continuous stream -> each beat's addr_out matches the mode value at its own acceptance.

Source files
------------

// File: rtl/pre_comm_remap.sv
// Per-channel 2-stage address remapper in front of the pre-commutator.
// Spreads nOUT outputs over nPIPE pipelines as {pipe, local}; drops out-of-range beats.
module pre_comm_remap #(
    parameter int nIN   = 8,
    parameter int nOUT  = 52,
    parameter int nPIPE = 4,
    parameter int wD    = 25,
    parameter int wCNT  = 16,
    localparam int wA_OUT = $clog2(nOUT),
    localparam int nCH    = (nOUT + nPIPE - 1) / nPIPE,
    localparam int wA_CH  = $clog2(nCH),
    localparam int wP     = $clog2(nPIPE),
    localparam int wA_MAP = wP + wA_CH
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    mode_bal,
    input  logic [nIN-1:0]          req_in,
    input  logic [wD*nIN-1:0]       data_in,
    input  logic [wA_OUT*nIN-1:0]   addr_in,
    output logic [nIN-1:0]          rdy_out,
    output logic [nIN-1:0]          req_out,
    output logic [wD*nIN-1:0]       data_out,
    output logic [wA_MAP*nIN-1:0]   addr_out,
    input  logic [nIN-1:0]          rdy_in,
    output logic [nIN-1:0]          err_out,
    output logic [wCNT*nIN-1:0]     drop_cnt
);

    for (genvar g = 0; g < nIN; g++) begin : g_ch
        logic              v1;
        logic              v2;
        logic              m1;
        logic              err;
        logic [wD-1:0]     d1;
        logic [wD-1:0]     d2;
        logic [wA_OUT-1:0] a1;
        logic [wA_MAP-1:0] a2;
        logic [wCNT-1:0]   cnt;
        logic [wP-1:0]     p;
        logic              oob;
        logic [wA_CH-1:0]  loc;
        logic [wA_MAP-1:0] map;
        logic              s2_free;
        logic              rdy;
        logic              acc;
        logic              mv;
        logic              drop;

        // Pipe index from a comparator ladder instead of a divider.
        always_comb begin
            p = '0;
            for (int k = 1; k < nPIPE; k++) begin
                if (int'(a1) >= k * nCH) p = p + wP'(1);
            end
        end

        assign oob     = int'(a1) >= nOUT;
        assign loc     = wA_CH'(int'(a1) - int'(p) * nCH);
        assign map     = m1 ? {p, loc} : wA_MAP'(a1);
        assign s2_free = !v2 | rdy_in[g];
        assign rdy     = reset & (!v1 | s2_free);
        assign acc     = req_in[g] & rdy;
        assign mv      = v1 & !oob & s2_free;
        // An out-of-range beat leaves S1 regardless of S2 state.
        assign drop    = v1 & oob;

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                v1  <= 1'b0;
                v2  <= 1'b0;
                m1  <= 1'b0;
                err <= 1'b0;
                d1  <= '0;
                d2  <= '0;
                a1  <= '0;
                a2  <= '0;
                cnt <= '0;
            end else begin
                if (acc) begin
                    v1 <= 1'b1;
                    d1 <= data_in[g*wD +: wD];
                    a1 <= addr_in[g*wA_OUT +: wA_OUT];
                    m1 <= mode_bal;
                end else if (mv | drop) begin
                    v1 <= 1'b0;
                end
                if (s2_free) begin
                    v2 <= mv;
                    if (mv) begin
                        d2 <= d1;
                        a2 <= map;
                    end
                end
                err <= drop;
                if (drop && cnt != {wCNT{1'b1}}) cnt <= cnt + wCNT'(1);
            end
        end

        assign rdy_out[g]                   = rdy;
        assign req_out[g]                   = v2;
        assign err_out[g]                   = err;
        assign data_out[g*wD +: wD]         = d2;
        assign addr_out[g*wA_MAP +: wA_MAP] = a2;
        assign drop_cnt[g*wCNT +: wCNT]     = cnt;
    end

endmodule

// File: tb/tb_pre_comm_remap.sv
// Bench for pre_comm_remap: vector table, directed corner sequences and a
// randomized run against a divide/modulo reference with per-channel scoreboards.
module tb_pre_comm_remap;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic mode_bal = 1'b0;
    always #5 clk = ~clk;

    // dut0: default geometry, 8 channels
    logic [7:0]   req_in0 = '0, rdy_in0 = '0;
    logic [199:0] data_in0 = '0;
    logic [47:0]  addr_in0 = '0;
    logic [7:0]   rdy_out0, req_out0, err_out0;
    logic [199:0] data_out0;
    logic [47:0]  addr_out0;
    logic [127:0] drop_cnt0;
    // dut1: nOUT=40, nPIPE=2
    logic [0:0]   req_in1 = '0, rdy_in1 = '0;
    logic [24:0]  data_in1 = '0;
    logic [5:0]   addr_in1 = '0;
    logic [0:0]   rdy_out1, req_out1, err_out1;
    logic [24:0]  data_out1;
    logic [5:0]   addr_out1;
    logic [15:0]  drop_cnt1;
    // dut2: 2-bit drop counter
    logic [0:0]   req_in2 = '0, rdy_in2 = '0;
    logic [24:0]  data_in2 = '0;
    logic [5:0]   addr_in2 = '0;
    logic [0:0]   rdy_out2, req_out2, err_out2;
    logic [24:0]  data_out2;
    logic [5:0]   addr_out2;
    logic [1:0]   drop_cnt2;

    pre_comm_remap u_dut0 (
        .clk(clk), .reset(reset), .mode_bal(mode_bal),
        .req_in(req_in0), .data_in(data_in0), .addr_in(addr_in0),
        .rdy_out(rdy_out0), .req_out(req_out0), .data_out(data_out0),
        .addr_out(addr_out0), .rdy_in(rdy_in0), .err_out(err_out0),
        .drop_cnt(drop_cnt0)
    );

    pre_comm_remap #(.nIN(1), .nOUT(40), .nPIPE(2)) u_dut1 (
        .clk(clk), .reset(reset), .mode_bal(mode_bal),
        .req_in(req_in1), .data_in(data_in1), .addr_in(addr_in1),
        .rdy_out(rdy_out1), .req_out(req_out1), .data_out(data_out1),
        .addr_out(addr_out1), .rdy_in(rdy_in1), .err_out(err_out1),
        .drop_cnt(drop_cnt1)
    );

    pre_comm_remap #(.nIN(1), .wCNT(2)) u_dut2 (
        .clk(clk), .reset(reset), .mode_bal(mode_bal),
        .req_in(req_in2), .data_in(data_in2), .addr_in(addr_in2),
        .rdy_out(rdy_out2), .req_out(req_out2), .data_out(data_out2),
        .addr_out(addr_out2), .rdy_in(rdy_in2), .err_out(err_out2),
        .drop_cnt(drop_cnt2)
    );

    typedef struct {
        int dut;
        bit mode;
        int addr;
        int exp;
    } vec_t;

    typedef struct {
        logic [24:0] d;
        int a;
    } beat_t;

    int total = 0;
    int bad = 0;
    beat_t sb[8][$];
    int exp_drop[8];
    int errs[8];
    int delivered[8];
    bit last_acc[8];

    task automatic chk(string name, longint act, longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Pipe = addr / nCH, local = addr % nCH, packed on a 2**wA_CH grid.
    function automatic int ref_map(bit mode, int a, int nch, int wach);
        if (!mode) return a;
        return (a / nch) * (1 << wach) + (a % nch);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic observe();
        beat_t e;
        int a;
        for (int c = 0; c < 8; c++) begin
            last_acc[c] = 1'b0;
            if (req_out0[c] && rdy_in0[c]) begin
                delivered[c]++;
                if (sb[c].size() == 0) begin
                    chk($sformatf("extra_beat_ch%0d", c), 1, 0);
                end else begin
                    e = sb[c].pop_front();
                    chk($sformatf("deliv_data_ch%0d", c),
                        longint'(data_out0[c*25 +: 25]), longint'(e.d));
                    chk($sformatf("deliv_addr_ch%0d", c),
                        longint'(addr_out0[c*6 +: 6]), longint'(e.a));
                end
            end
            if (req_in0[c] && rdy_out0[c]) begin
                last_acc[c] = 1'b1;
                a = int'(addr_in0[c*6 +: 6]);
                if (a >= 52) begin
                    exp_drop[c]++;
                end else begin
                    e.d = data_in0[c*25 +: 25];
                    e.a = ref_map(mode_bal, a, 13, 4);
                    sb[c].push_back(e);
                end
            end
            errs[c] += int'(err_out0[c]);
        end
    endtask

    task automatic cyc();
        #1;
        observe();
        tick();
    endtask

    task automatic clear_model();
        for (int c = 0; c < 8; c++) begin
            sb[c].delete();
            exp_drop[c] = 0;
            errs[c] = 0;
            delivered[c] = 0;
        end
    endtask

    task automatic drive0(int c, int a, logic [24:0] d);
        req_in0[c] = 1'b1;
        addr_in0[c*6 +: 6] = 6'(a);
        data_in0[c*25 +: 25] = d;
    endtask

    vec_t vt[$];
    beat_t bp[4];

    initial begin
        logic [24:0] d;
        int idx;
        int ad;
        clear_model();

        // Reset state
        #12;
        chk("rst_rdy_out", rdy_out0, 0);
        chk("rst_req_out", req_out0, 0);
        chk("rst_err_out", err_out0, 0);
        chk("rst_drop_cnt", drop_cnt0, 0);
        chk("rst_data_out", data_out0, 0);
        reset = 1'b1;
        #1;
        chk("rel_rdy_out", rdy_out0, 8'hFF);
        tick();

        // Vector table, rdy_in held high
        vt.push_back('{0, 1, 0, 0});
        vt.push_back('{0, 1, 12, 12});
        vt.push_back('{0, 1, 13, 16});
        vt.push_back('{0, 1, 27, 33});
        vt.push_back('{0, 1, 51, 60});
        vt.push_back('{0, 0, 51, 51});
        vt.push_back('{0, 0, 13, 13});
        vt.push_back('{1, 1, 19, 19});
        vt.push_back('{1, 1, 20, 32});
        vt.push_back('{1, 1, 25, 37});
        vt.push_back('{1, 0, 25, 25});
        vt.push_back('{1, 1, 39, 51});
        rdy_in0 = '1;
        rdy_in1 = '1;
        foreach (vt[i]) begin
            d = 25'($urandom);
            mode_bal = vt[i].mode;
            if (vt[i].dut == 0) drive0(0, vt[i].addr, d);
            else begin
                req_in1 = 1'b1;
                addr_in1 = 6'(vt[i].addr);
                data_in1 = d;
            end
            #1;
            chk("vec_rdy", vt[i].dut == 0 ? rdy_out0[0] : rdy_out1[0], 1);
            tick();
            req_in0 = '0;
            req_in1 = '0;
            chk("vec_lat1", vt[i].dut == 0 ? req_out0[0] : req_out1[0], 0);
            tick();
            if (vt[i].dut == 0) begin
                chk("vec_req0", req_out0[0], 1);
                chk("vec_addr0", addr_out0[5:0], vt[i].exp);
                chk("vec_data0", data_out0[24:0], d);
            end else begin
                chk("vec_req1", req_out1[0], 1);
                chk("vec_addr1", addr_out1, vt[i].exp);
                chk("vec_data1", data_out1, d);
            end
            tick();
        end

        // Backpressure: 4 beats into a stalled channel
        mode_bal = 1'b1;
        rdy_in0 = '0;
        bp[0] = '{25'h0ABCDE, 3};
        bp[1] = '{25'h1234567, 14};
        bp[2] = '{25'h0F0F0F, 30};
        bp[3] = '{25'h1555555, 45};
        idx = 0;
        for (int k = 0; k < 5; k++) begin
            drive0(0, bp[idx].a, bp[idx].d);
            cyc();
            if (last_acc[0]) idx++;
            if (k >= 1) begin
                chk("bp_req_held", req_out0[0], 1);
                chk("bp_data_held", data_out0[24:0], bp[0].d);
                chk("bp_addr_held", addr_out0[5:0], ref_map(1, bp[0].a, 13, 4));
            end
        end
        chk("bp_accepted", idx, 2);
        chk("bp_rdy_low", rdy_out0[0], 0);
        rdy_in0 = '1;
        for (int k = 0; k < 20; k++) begin
            if (idx < 4) drive0(0, bp[idx].a, bp[idx].d);
            else req_in0 = '0;
            cyc();
            if (last_acc[0]) idx++;
        end
        chk("bp_delivered", delivered[0], 4);
        chk("bp_sb_empty", sb[0].size(), 0);

        // Out-of-range beat while S2 is stalled
        rdy_in0 = '0;
        drive0(0, 5, 25'h0000AA);
        cyc();
        req_in0 = '0;
        cyc();
        drive0(0, 55, 25'h0000BB);
        cyc();
        chk("oob_acc", last_acc[0], 1);
        req_in0 = '0;
        cyc();
        chk("oob_err_pulse", err_out0[0], 1);
        chk("oob_cnt", drop_cnt0[15:0], 1);
        drive0(0, 20, 25'h0000CC);
        cyc();
        chk("oob_err_clear", err_out0[0], 0);
        chk("oob_next_acc", last_acc[0], 1);
        req_in0 = '0;
        rdy_in0 = '1;
        for (int k = 0; k < 4; k++) cyc();
        chk("oob_sb_empty", sb[0].size(), 0);
        chk("oob_cnt_hold", drop_cnt0[15:0], 1);

        // Saturating 2-bit counter
        rdy_in2 = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            req_in2 = 1'b1;
            addr_in2 = 6'd60;
            data_in2 = 25'(k);
            tick();
            req_in2 = 1'b0;
            tick();
            chk("sat_err", err_out2[0], 1);
            chk("sat_cnt", drop_cnt2, k < 3 ? k : 3);
        end
        chk("sat_no_out", req_out2[0], 0);

        // mode_bal toggling on a continuous stream
        rdy_in0 = '1;
        for (int k = 0; k < 10; k++) begin
            mode_bal = k[0];
            drive0(2, int'($urandom_range(0, 51)), 25'($urandom));
            cyc();
            chk("tog_acc", last_acc[2], 1);
        end
        req_in0 = '0;
        for (int k = 0; k < 3; k++) cyc();
        chk("tog_sb_empty", sb[2].size(), 0);

        // Asynchronous reset with both stages full
        rdy_in0 = '0;
        drive0(0, 7, 25'h000111);
        cyc();
        drive0(0, 8, 25'h000222);
        cyc();
        req_in0 = '0;
        #2;
        reset = 1'b0;
        #1;
        chk("arst_req_out", req_out0, 0);
        chk("arst_err_out", err_out0, 0);
        chk("arst_drop_cnt", drop_cnt0, 0);
        chk("arst_rdy_out", rdy_out0, 0);
        chk("arst_data_out", data_out0, 0);
        clear_model();
        tick();
        #3;
        reset = 1'b1;
        #1;
        chk("arst_rel_rdy", rdy_out0[0], 1);
        tick();
        chk("arst_no_ghost", req_out0, 0);
        rdy_in0 = '1;
        mode_bal = 1'b1;
        drive0(0, 40, 25'h000333);
        tick();
        req_in0 = '0;
        chk("arst_lat1", req_out0[0], 0);
        tick();
        chk("arst_lat2_req", req_out0[0], 1);
        chk("arst_lat2_addr", addr_out0[5:0], 49);
        tick();
        clear_model();

        // Randomized traffic on all channels
        for (int k = 0; k < 600; k++) begin
            mode_bal = 1'($urandom);
            for (int c = 0; c < 8; c++) begin
                req_in0[c] = ($urandom_range(0, 3) != 0);
                rdy_in0[c] = ($urandom_range(0, 9) < 7);
                ad = ($urandom_range(0, 7) == 0) ? int'($urandom_range(52, 63))
                                                 : int'($urandom_range(0, 51));
                addr_in0[c*6 +: 6] = 6'(ad);
                data_in0[c*25 +: 25] = 25'($urandom);
            end
            cyc();
        end
        req_in0 = '0;
        rdy_in0 = '1;
        for (int k = 0; k < 5; k++) cyc();
        for (int c = 0; c < 8; c++) begin
            chk($sformatf("rnd_sb_empty_ch%0d", c), sb[c].size(), 0);
            chk($sformatf("rnd_drop_ch%0d", c), drop_cnt0[c*16 +: 16], exp_drop[c]);
            chk($sformatf("rnd_err_ch%0d", c), errs[c], exp_drop[c]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
